// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array output path.
//
// Contents:
//   SIZE_DEF, DATA_W_DEF : default array dimension and result word width
//   drain_state_e        : one-hot state encoding of the result drain FSM
package systolic_pkg;

    localparam int SIZE_DEF   = 4;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        DRAIN_IDLE = 3'b001,
        DRAIN_SEND = 3'b010,
        DRAIN_DONE = 3'b100
    } drain_state_e;

endpackage

// File: rtl/systolic_result_bank.sv
// Snapshot bank holding one full SIZE x SIZE result matrix.
//
// Ports:
//   clk   : rising-edge clock
//   load  : single load-enable, captures the whole flat matrix in one edge
//   data  : flat matrix, element i at bits [i*DATA_W +: DATA_W]
//   idx   : read index (row-major element number)
//   word  : stored word at idx (zero for an index beyond the matrix)
module systolic_result_bank
    import systolic_pkg::*;
#(
    parameter  int SIZE   = SIZE_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    localparam int DEPTH  = SIZE * SIZE,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    load,
    input  logic [DEPTH*DATA_W-1:0] data,
    input  logic [IDX_W-1:0]        idx,
    output logic [DATA_W-1:0]       word
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Data registers carry no reset: their contents only matter after a load.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= data[i*DATA_W +: DATA_W];
            end
        end
    end

    // When DEPTH is not a power of two the index field can exceed the bank.
    always_comb begin
        word = '0;
        if (int'(idx) < DEPTH) begin
            word = mem[idx];
        end
    end

endmodule

// File: rtl/systolic_drain.sv
// Result drain for the systolic array: snapshots the SIZE x SIZE result
// matrix when the array reports results ready, streams it out row-major over
// a val/rdy interface, then holds array_clr until the array drops out_rdy.
//
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   out_rdy    : array results valid and stable (level)
//   pe_result  : flat result matrix, (r,c) at [(r*SIZE+c)*DATA_W +: DATA_W]
//   send_val   : send_msg carries a valid word
//   send_rdy   : consumer accepts the word this cycle
//   send_msg   : current result word
//   send_last  : marks element (SIZE-1,SIZE-1)
//   array_clr  : request to the array to clear and return to load
//   busy       : drain is not idle
module systolic_drain
    import systolic_pkg::*;
#(
    parameter int SIZE   = SIZE_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        out_rdy,
    input  logic [SIZE*SIZE*DATA_W-1:0] pe_result,
    output logic                        send_val,
    input  logic                        send_rdy,
    output logic [DATA_W-1:0]           send_msg,
    output logic                        send_last,
    output logic                        array_clr,
    output logic                        busy
);

    localparam int DEPTH = SIZE * SIZE;
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    drain_state_e      state_r, state_nxt;
    logic [IDX_W-1:0]  idx_r, idx_nxt;
    logic              capture;
    logic              at_last;
    logic [DATA_W-1:0] bank_word;

    systolic_result_bank #(
        .SIZE   (SIZE),
        .DATA_W (DATA_W)
    ) u_bank (
        .clk  (clk),
        .load (capture),
        .data (pe_result),
        .idx  (idx_r),
        .word (bank_word)
    );

    assign at_last = (idx_r == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= DRAIN_IDLE;
            idx_r   <= '0;
        end else begin
            state_r <= state_nxt;
            idx_r   <= idx_nxt;
        end
    end

    // Outputs decode only the registered state and index, so nothing on the
    // send side depends combinationally on send_rdy.
    always_comb begin
        state_nxt = state_r;
        idx_nxt   = idx_r;
        capture   = 1'b0;
        send_val  = 1'b0;
        send_last = 1'b0;
        send_msg  = '0;
        array_clr = 1'b0;
        busy      = 1'b1;

        case (state_r)
            DRAIN_IDLE: begin
                busy = 1'b0;
                if (out_rdy) begin
                    capture   = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = DRAIN_SEND;
                end
            end

            DRAIN_SEND: begin
                send_val  = 1'b1;
                send_last = at_last;
                send_msg  = bank_word;
                if (send_rdy) begin
                    if (at_last) begin
                        state_nxt = DRAIN_DONE;
                    end else begin
                        idx_nxt = idx_r + IDX_W'(1);
                    end
                end
            end

            // Waiting for out_rdy to fall keeps the same frame from being
            // captured a second time.
            DRAIN_DONE: begin
                array_clr = 1'b1;
                if (!out_rdy) begin
                    state_nxt = DRAIN_IDLE;
                end
            end

            default: begin
                state_nxt = DRAIN_IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

endmodule

// File: doc/systolic_drain.md
# systolic_drain

Output-side companion to the systolic array controller: once the array asserts `out_rdy`, the drain snapshots the full SIZE×SIZE result matrix. It then streams the matrix out row-major, one word per handshake, over a val/rdy send interface with a last-word flag. When the frame completes, it holds `array_clr` until the array drops `out_rdy`, returning the array path to its load phase. It sits between the PE result outputs and the downstream consumer (SPI/serializer or memory writer).

## Interface

Reset is asynchronous and active-low (`rst_n`); one clock (`clk`).

- `SIZE`, default 4: array dimension; SIZE ≥ 2.
- `DATA_W`, default 32: result word width.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `out_rdy`  in  1  level; array results are valid and stable while high.
- `pe_result`  in  SIZE*SIZE*DATA_W  flat matrix; element (r,c) at bits [(r*SIZE+c)*DATA_W +: DATA_W].
- `send_val`  out  1  `send_msg` holds a valid result word.
- `send_rdy`  in  1  consumer accepts the word this cycle.
- `send_msg`  out  DATA_W  current result word.
- `send_last`  out  1  high with `send_val` on element (SIZE-1,SIZE-1).
- `array_clr`  out  1  level request to the array/controller to clear its results and return to load.
- `busy`  out  1  high in any state other than IDLE.

## Operation

- States are one-hot, 3 bits: IDLE=3'b001, SEND=3'b010, DONE=3'b100. Any other encoding goes to IDLE.
- IDLE:
  - If `out_rdy`=1: capture all of `pe_result` into the snapshot bank, set idx=0, and go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - `send_val`=1 and `send_msg`=snapshot[idx].
  - On `send_val & send_rdy`:
    - If idx==SIZE*SIZE-1: go to DONE.
    - Otherwise idx←idx+1.
  - With no handshake, idx and `send_msg` hold.
  - `out_rdy` is ignored in SEND; the snapshot is immune to PE changes.
- DONE:
  - `array_clr`=1.
  - When `out_rdy`=0, go to IDLE. This rule prevents recapturing the same frame.
- Ordering is row-major: idx = r*SIZE+c. Words pass through without truncation or sign change.
- idx width is $clog2(SIZE*SIZE). The terminal compare is exact, with no reliance on wrap-around.
- `send_last` = SEND & (idx==SIZE*SIZE-1).

## Timing

- Reset, asynchronous, effective immediately:
  - state=IDLE, idx=0.
  - `send_val`=0, `send_last`=0, `array_clr`=0, `busy`=0, `send_msg`=0.
  - Snapshot contents are don't-care.
- Capture occurs on the rising edge where state=IDLE and `out_rdy`=1. `send_val` rises the following cycle, giving 1-cycle latency from `out_rdy` to the first word.
- `send_val`, `send_msg` and `send_last` depend only on registered state and idx, never combinationally on `send_rdy`.
- Once `send_val` is high, `send_val` and `send_msg` remain stable until the handshake.
- Throughput is one word per cycle with `send_rdy` held high. A full frame takes SIZE*SIZE cycles in SEND.
- `array_clr` rises the cycle after the last handshake and stays high while `out_rdy`=1. Its minimum high time is 1 cycle. If `out_rdy` is already 0 on entry to DONE, DONE lasts exactly 1 cycle.
- Reset asserted mid-SEND abandons the frame; no partial resume. If `out_rdy` is still high after reset, a fresh capture occurs.
- `send_rdy` high while `send_val` is low has no effect.

## Structure

- Package `systolic_pkg`:
  - state encodings `DRAIN_IDLE`, `DRAIN_SEND`, `DRAIN_DONE`.
  - the shared `SIZE`/`DATA_W` defaults, consistent with the controller's one-hot style.
- Sub-module `systolic_result_bank`:
  - SIZE*SIZE×DATA_W registers with a single load-enable.
  - indexed read port: idx → word.
- `systolic_drain` holds the FSM, index counter and handshake logic.

## Test plan

All scenarios use SIZE=2, DATA_W=8.

- **Basic frame:** `pe_result`={(0,0)=0x11,(0,1)=0x22,(1,0)=0x33,(1,1)=0x44}, `out_rdy`=1, `send_rdy`=1.
  - Words 0x11,0x22,0x33,0x44 on 4 consecutive cycles, first word 1 cycle after capture.
  - `send_last` only on 0x44.
  - `array_clr` high the next cycle.
- **Backpressure:** `send_rdy` toggles 0,1,0,0,1,…
  - Same 4 words in order, none dropped or duplicated.
  - `send_msg` stable while stalled.
- **Snapshot immunity:** change `pe_result` to all 0xFF one cycle after capture.
  - Output is still 0x11..0x44.
- **Clear handshake:** hold `out_rdy`=1 for 5 cycles after the last word.
  - `array_clr` stays high 5 cycles, then IDLE.
  - No second frame emitted.
  - Re-raising `out_rdy` with new data 0xA0..0xA3 streams 0xA0..0xA3.
- **Reset mid-frame:** assert `rst_n`=0 after the 2nd word.
  - All outputs 0 asynchronously.
  - After release with `out_rdy`=1, a full frame restarts at 0x11.
